// File: rtl/random_range_sampler.sv
// Rejection sampler: draws uniform values below a requested limit from an upstream
// random word, falling back to 0 after MAX_TRIES rejects. SAMPLER_STATS_EN enables reject_cnt.
module random_range_sampler #(
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rand_in,
  input  logic [3:0] limit,
  input  logic       start,
  output logic       busy,
  output logic       valid,
  output logic [3:0] value,
  input  logic       ack,
  output logic       fallback,
  output logic [7:0] reject_cnt
);

  // Handshake: a request is taken when start=1 is sampled while busy=0; a result is
  // offered while valid=1 and held stable until ack=1 is sampled, which retires it.

  typedef enum logic [1:0] {IDLE, SAMPLE, HOLD} state_t;

  localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

  state_t     state, state_n;
  logic [3:0] lim, lim_n;
  logic [7:0] tries, tries_n;
  logic [3:0] value_n;
  logic       fallback_n;
  logic [4:0] eff_lim;
  logic       accept;

  // A latched limit of 0 stands for the full 16-value range.
  assign eff_lim = (lim == 4'd0) ? 5'd16 : {1'b0, lim};
  assign accept  = ({1'b0, rand_in} < eff_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lim      <= '0;
      tries    <= '0;
      value    <= '0;
      fallback <= 1'b0;
    end else begin
      state    <= state_n;
      lim      <= lim_n;
      tries    <= tries_n;
      value    <= value_n;
      fallback <= fallback_n;
    end
  end

  always_comb begin
    state_n    = state;
    lim_n      = lim;
    tries_n    = tries;
    value_n    = value;
    fallback_n = fallback;
    case (state)
      IDLE: begin
        if (start) begin
          lim_n   = limit;
          tries_n = 8'd0;
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        if (accept) begin
          value_n    = rand_in;
          fallback_n = 1'b0;
          state_n    = HOLD;
        end else begin
          tries_n = tries + 8'd1;
          if (tries == LAST_TRY) begin
            value_n    = 4'd0;
            fallback_n = 1'b1;
            state_n    = HOLD;
          end
        end
      end
      HOLD: begin
        if (ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign valid = (state == HOLD);

`ifdef SAMPLER_STATS_EN
  logic reject;
  assign reject = (state == SAMPLE) && !accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      reject_cnt <= '0;
    else if (reject && reject_cnt != 8'hFF)
      reject_cnt <= reject_cnt + 8'd1;
  end
`else
  assign reject_cnt = '0;
`endif

endmodule

// File: tb/tb_random_range_sampler.sv
// Scoreboard bench for random_range_sampler: a driver issues requests and pushes the
// expected {fallback, value, latency}; a monitor pops and compares when valid rises.
module tb_random_range_sampler;

  localparam int MT = 8;
  localparam int W  = 13;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rand_in = '0;
  logic [3:0] limit = '0;
  logic       start = 1'b0;
  logic       ack = 1'b0;
  logic       busy, valid, fallback;
  logic [3:0] value;
  logic [7:0] reject_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int exp_rej = 0;

  logic [W-1:0] exp_q[$];
  logic [3:0]   seq_buf [0:MT-1];

  random_range_sampler #(.MAX_TRIES(MT)) dut (
    .clk(clk), .rst(rst), .rand_in(rand_in), .limit(limit), .start(start),
    .busy(busy), .valid(valid), .value(value), .ack(ack),
    .fallback(fallback), .reject_cnt(reject_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int exp_stats(input int n);
`ifdef SAMPLER_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // ---------------- reference model ----------------
  // Returns {fallback, value, latency}; adds this request's rejects to exp_rej.
  function automatic logic [W-1:0] model(input logic [3:0] l);
    int eff = (l == 0) ? 16 : int'(l);
    for (int i = 0; i < MT; i++) begin
      if (int'(seq_buf[i]) < eff) begin
        exp_rej = (exp_rej + i > 255) ? 255 : exp_rej + i;
        return {1'b0, seq_buf[i], 8'(i + 1)};
      end
    end
    exp_rej = (exp_rej + MT > 255) ? 255 : exp_rej + MT;
    return {1'b1, 4'd0, 8'(MT)};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic         seen = 1'b0;
  logic [3:0]   cap_val;
  logic         cap_fb;
  logic [W-1:0] exp_r, got_r;

  always @(negedge clk) begin
    if (rst || !valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen    = 1'b1;
      cap_val = value;
      cap_fb  = fallback;
      got_r   = {fallback, value, 8'(cyc - start_cyc)};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got fb=%0d val=%0d with nothing expected", fallback, value);
      end else begin
        exp_r = exp_q.pop_front();
        if (got_r != exp_r) begin
          failures++;
          $display("FAIL result: got fb=%0d val=%0d lat=%0d expected fb=%0d val=%0d lat=%0d",
                   got_r[12], got_r[11:8], got_r[7:0], exp_r[12], exp_r[11:8], exp_r[7:0]);
        end
      end
    end else begin
      checks++;
      if (value != cap_val || fallback != cap_fb || !busy) begin
        failures++;
        $display("FAIL hold_stable: got val=%0d fb=%0d busy=%0d expected val=%0d fb=%0d busy=1",
                 value, fallback, busy, cap_val, cap_fb);
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one request using seq_buf as the per-cycle rand_in stream, holds the
  // result for n_hold cycles, then retires it with ack (start also raised).
  task automatic run_req(input logic [3:0] l, input int n_hold);
    int waited;
    exp_q.push_back(model(l));
    @(negedge clk);
    limit   = l;
    start   = 1'b1;
    rand_in = 4'($urandom_range(0, 15));
    @(negedge clk);
    start_cyc = cyc;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int k = 0; k < MT; k++) begin
      if (valid) break;
      rand_in = seq_buf[k];
      limit   = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    waited = 0;
    while (!valid && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    chk("valid_reached", int'(valid), 1);
    chk("reject_cnt", int'(reject_cnt), exp_stats(exp_rej));
    for (int h = 0; h < n_hold; h++) begin
      rand_in = 4'($urandom_range(0, 15));
      limit   = 4'($urandom_range(0, 15));
      start   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ack   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
    chk("valid_after_ack", int'(valid), 0);
    chk("busy_after_ack", int'(busy), 0);
    @(negedge clk);
    chk("idle_no_new_req", int'(busy), 0);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL missing_result: got no result, expected %0d pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic fill_seq(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] rest);
    for (int i = 0; i < MT; i++) seq_buf[i] = rest;
    seq_buf[0] = a;
    seq_buf[1] = b;
    seq_buf[2] = c;
  endtask

  initial begin
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_value", int'(value), 0);
    chk("rst_fallback", int'(fallback), 0);
    chk("rst_reject_cnt", int'(reject_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ack outside HOLD must do nothing
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_in_idle", int'(busy), 0);

    fill_seq(4'd3, 4'd3, 4'd3, 4'd3);   run_req(4'd10, 2);
    fill_seq(4'd9, 4'd12, 4'd2, 4'd2);  run_req(4'd4, 1);
    fill_seq(4'd15, 4'd15, 4'd15, 4'd15); run_req(4'd1, 5);
    fill_seq(4'd7, 4'd0, 4'd0, 4'd0);   run_req(4'd1, 0);
    fill_seq(4'd9, 4'd1, 4'd1, 4'd1);   run_req(4'd0, 1);

    // Reset during SAMPLE after three rejections abandons the request
    fill_seq(4'd15, 4'd15, 4'd15, 4'd15);
    @(negedge clk);
    limit = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_in = seq_buf[k];
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("midreq_rst_busy", int'(busy), 0);
    chk("midreq_rst_valid", int'(valid), 0);
    chk("midreq_rst_reject_cnt", int'(reject_cnt), 0);
    exp_rej = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_result_after_rst", int'(valid), 0);
    end
    fill_seq(4'd3, 4'd3, 4'd3, 4'd3);   run_req(4'd10, 1);

    // Randomized requests
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < MT; i++) seq_buf[i] = 4'($urandom_range(0, 15));
      run_req(4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
